// File: rtl/adc_volt_meas.sv
// adc_volt_meas: ADC sample-clock generator, start-up zero-point calibration,
// window averaging and conversion to a signed millivolt magnitude.
//
// state  | meaning
// CAL    | sum 2^CAL_LOG2 samples; mid = zero-point code
// DIV_P  | K_P = (FULL_MV<<13)/(255-mid), one quotient bit per cycle
// DIV_N  | K_N = (FULL_MV<<13)/mid, one quotient bit per cycle
// RUN    | average 2^AVG_LOG2-sample windows and convert to mV
module adc_volt_meas #(
    parameter int AD_CLK_DIV = 4,
    parameter int CAL_LOG2   = 10,
    parameter int AVG_LOG2   = 4,
    parameter int FULL_MV    = 5000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  ad_data,
    input  logic        recal,
    output logic        ad_clk,
    output logic [15:0] volt,
    output logic        sign,
    output logic        volt_vld,
    output logic        cal_done
);
    localparam int DCW = $clog2(AD_CLK_DIV);
    localparam int AW  = CAL_LOG2 + 8;
    localparam int QW  = 26;
    localparam logic [QW-1:0] DIVIDEND  = QW'(FULL_MV * 8192);
    localparam logic [4:0]    LAST_STEP = 5'(QW - 1);

    typedef enum logic [1:0] {ST_CAL, ST_DIV_P, ST_DIV_N, ST_RUN} state_e;
    state_e state_q, state_d;

    logic [DCW-1:0]      div_cnt_q, div_cnt_d;
    logic                ad_clk_q;
    logic                samp_en;

    logic [AW-1:0]       acc_q, acc_sum;
    logic [CAL_LOG2-1:0] cnt_q;
    logic                cal_last, win_last;
    logic [7:0]          mid_q;
    logic [QW-1:0]       kp_q, kn_q;

    logic [7:0]          rem_q, rem_nx, divisor;
    logic [8:0]          rem_sh;
    logic                rem_ge;
    logic [QW-1:0]       quo_q, quo_nx;
    logic [4:0]          step_q;
    logic                div_last;

    logic [7:0]          avg_q, diff_q;
    logic [QW-1:0]       k_q;
    logic [33:0]         prod_q;
    logic                v0_q, v1_q, v2_q, sgn1_q, sgn2_q;
    logic [15:0]         volt_q;
    logic                sign_q, vld_q;
    logic                unused_prod;

    // Sample-clock divider and sample strobe; ad_clk is registered from the next count
    always_comb begin
        samp_en   = (div_cnt_q == DCW'(AD_CLK_DIV - 1));
        div_cnt_d = samp_en ? '0 : div_cnt_q + 1'b1;
    end

    // Divider phase counter and ad_clk register; recal deliberately does not touch them
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            div_cnt_q <= '0;
            ad_clk_q  <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            ad_clk_q  <= (div_cnt_d < DCW'(AD_CLK_DIV / 2));
        end
    end

    // Sample bookkeeping and one restoring-divider step
    always_comb begin
        acc_sum  = acc_q + AW'(ad_data);
        cal_last = samp_en && (cnt_q == '1);
        win_last = samp_en && (cnt_q[AVG_LOG2-1:0] == '1);
        div_last = (step_q == LAST_STEP);
        divisor  = (state_q == ST_DIV_P) ? 8'd255 - mid_q : mid_q;
        if (divisor == 8'd0) begin
            divisor = 8'd1;
        end
        rem_sh = {rem_q, DIVIDEND[LAST_STEP - step_q]};
        rem_ge = (rem_sh >= {1'b0, divisor});
        rem_nx = rem_ge ? 8'(rem_sh - {1'b0, divisor}) : rem_sh[7:0];
        quo_nx = {quo_q[QW-2:0], rem_ge};
    end

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_CAL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; recal overrides everything
    always_comb begin
        state_d = state_q;
        if (recal) begin
            state_d = ST_CAL;
        end else begin
            case (state_q)
                ST_CAL:   if (cal_last) state_d = ST_DIV_P;
                ST_DIV_P: if (div_last) state_d = ST_DIV_N;
                ST_DIV_N: if (div_last) state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        cal_done = (state_q == ST_RUN);
    end

    // Accumulator, sample counter, divider registers and calibration factors
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            mid_q  <= '0;
            kp_q   <= '0;
            kn_q   <= '0;
        end else begin
            if (recal || (state_d != state_q)) begin
                acc_q  <= '0;
                cnt_q  <= '0;
                rem_q  <= '0;
                quo_q  <= '0;
                step_q <= '0;
            end else if (state_q == ST_CAL || state_q == ST_RUN) begin
                if (samp_en) begin
                    if (state_q == ST_RUN && win_last) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        acc_q <= acc_sum;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end else begin
                rem_q  <= rem_nx;
                quo_q  <= quo_nx;
                step_q <= step_q + 5'd1;
            end
            if (!recal) begin
                if (state_q == ST_CAL && cal_last) mid_q <= acc_sum[AW-1 -: 8];
                if (state_q == ST_DIV_P && div_last) kp_q <= quo_nx;
                if (state_q == ST_DIV_N && div_last) kn_q <= quo_nx;
            end
        end
    end

    // Conversion pipeline: average -> signed difference -> product -> saturated mV
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            avg_q  <= '0;
            v0_q   <= 1'b0;
            diff_q <= '0;
            k_q    <= '0;
            sgn1_q <= 1'b0;
            v1_q   <= 1'b0;
            prod_q <= '0;
            sgn2_q <= 1'b0;
            v2_q   <= 1'b0;
            volt_q <= '0;
            sign_q <= 1'b0;
            vld_q  <= 1'b0;
        end else if (recal) begin
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            v0_q <= (state_q == ST_RUN) && win_last;
            if ((state_q == ST_RUN) && win_last) avg_q <= acc_sum[AVG_LOG2 +: 8];
            v1_q <= v0_q;
            if (avg_q > mid_q) begin
                diff_q <= avg_q - mid_q;
                k_q    <= kp_q;
                sgn1_q <= 1'b0;
            end else if (avg_q < mid_q) begin
                diff_q <= mid_q - avg_q;
                k_q    <= kn_q;
                sgn1_q <= 1'b1;
            end else begin
                diff_q <= '0;
                k_q    <= kp_q;
                sgn1_q <= 1'b0;
            end
            v2_q   <= v1_q;
            prod_q <= 34'(diff_q) * 34'(k_q);
            sgn2_q <= sgn1_q;
            vld_q  <= v2_q;
            if (v2_q) begin
                volt_q <= (|prod_q[33:29]) ? 16'hFFFF : prod_q[28:13];
                sign_q <= sgn2_q;
            end
        end
    end

    assign unused_prod = ^prod_q[12:0];
    assign ad_clk      = ad_clk_q;
    assign volt        = volt_q;
    assign sign        = sign_q;
    assign volt_vld    = vld_q;
endmodule

// File: tb/tb_adc_volt_meas.sv
// Bench for adc_volt_meas: random and directed sample streams compared
// against an arithmetic reference of calibration and conversion.
module tb_adc_volt_meas;
    localparam longint DIVIDEND = 64'd5000 * 64'd8192;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [7:0]  ad_data;
    logic        recal;
    logic        ad_clk;
    logic [15:0] volt;
    logic        sign;
    logic        volt_vld;
    logic        cal_done;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;
    int     ph = 0;

    typedef struct {
        longint v;
        longint s;
        longint c;
    } exp_t;
    exp_t   exp_q[$];
    exp_t   mon_e;
    longint m_mid, m_kp, m_kn, m_volt, m_sign;

    adc_volt_meas dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .ad_data  (ad_data),
        .recal    (recal),
        .ad_clk   (ad_clk),
        .volt     (volt),
        .sign     (sign),
        .volt_vld (volt_vld),
        .cal_done (cal_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Expected ad_clk phase: four system cycles per sample period, restarted by reset
    always @(posedge sys_clk) ph <= (!sys_rst_n) ? 0 : ((ph == 3) ? 0 : ph + 1);

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1 && volt_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("vld_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("vld_cycle", cyc, mon_e.c);
                chk("volt", volt, mon_e.v);
                chk("sign", sign, mon_e.s);
            end
        end
    end

    function automatic longint kdiv(input longint d);
        return DIVIDEND / ((d == 0) ? 64'd1 : d);
    endfunction

    task automatic model_window(input longint sum, output longint v, output longint s);
        longint avg, diff, k, p;
        avg = sum / 16;
        if (avg > m_mid) begin
            diff = avg - m_mid; k = m_kp; s = 0;
        end else if (avg < m_mid) begin
            diff = m_mid - avg; k = m_kn; s = 1;
        end else begin
            diff = 0; k = 0; s = 0;
        end
        p = (diff * k) / 8192;
        v = (p > 65535) ? 65535 : p;
    endtask

    // Present one sample for exactly the edge that ends a div_cnt==3 cycle; junk otherwise
    task automatic samp(input int v, input bit rc);
        while (ph != 3) @(negedge sys_clk);
        ad_data = 8'(v);
        recal   = rc;
        @(posedge sys_clk);
        #1;
        recal   = 1'b0;
        ad_data = 8'($urandom);
    endtask

    task automatic pulse_recal();
        recal = 1'b1;
        @(posedge sys_clk);
        #1;
        recal = 1'b0;
        chk("recal_cal_done", cal_done, 0);
    endtask

    task automatic calibrate(input int mode, input int c, input int abort_at);
        longint sum = 0;
        int v;
        for (int i = 0; i < 1024; i++) begin
            v = (mode == 0) ? c : int'($urandom_range(c + 20, c - 20));
            sum += v;
            samp(v, 1'b0);
        end
        chk("cal_done_at_last", cal_done, 0);
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge sys_clk);
            #1;
            pulse_recal();
            chk("abort_volt_hold", volt, m_volt);
            chk("abort_sign_hold", sign, m_sign);
            return;
        end
        m_mid = sum / 1024;
        m_kp  = kdiv(255 - m_mid);
        m_kn  = kdiv(m_mid);
        repeat (51) @(posedge sys_clk);
        #1;
        chk("cal_done_early", cal_done, 0);
        @(posedge sys_clk);
        #1;
        chk("cal_done_rise", cal_done, 1);
    endtask

    task automatic run_window(input int mode, input int a, input int b, input bit rc);
        longint sum = 0;
        longint ev, es;
        int v;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            v = (mode == 0) ? a : (mode == 1) ? ((i < 8) ? a : b) : int'($urandom_range(255, 0));
            sum += v;
            samp(v, rc && (i == 15));
        end
        if (rc) begin
            chk("win_recal_cal_done", cal_done, 0);
            chk("win_recal_volt_hold", volt, m_volt);
        end else begin
            model_window(sum, ev, es);
            e.v = ev; e.s = es; e.c = cyc + 3;
            exp_q.push_back(e);
            m_volt = ev;
            m_sign = es;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge sys_clk);
            k++;
        end
        #1;
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ad_clk"}, ad_clk, 1);
        chk({tag, "_volt"}, volt, 0);
        chk({tag, "_sign"}, sign, 0);
        chk({tag, "_vld"}, volt_vld, 0);
        chk({tag, "_cal_done"}, cal_done, 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        ad_data   = 8'd0;
        recal     = 1'b0;
        m_mid = 0; m_kp = 0; m_kn = 0; m_volt = 0; m_sign = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_reset_state("reset");
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge sys_clk);
            #1;
            chk("ad_clk_phase", ad_clk, (ph < 2) ? 1 : 0);
        end
        pulse_recal();

        calibrate(0, 128, 0);
        run_window(0, 255, 0, 1'b0);
        run_window(0, 0, 0, 1'b0);
        run_window(0, 128, 0, 1'b0);
        run_window(1, 129, 130, 1'b0);
        for (int i = 0; i < 3; i++) run_window(2, 0, 0, 1'b0);
        drain();

        pulse_recal();
        calibrate(0, 0, 0);
        run_window(0, 255, 0, 1'b0);
        run_window(0, 0, 0, 1'b0);
        drain();
        pulse_recal();
        calibrate(0, 255, 0);
        run_window(0, 255, 0, 1'b0);
        run_window(0, 0, 0, 1'b0);
        run_window(2, 0, 0, 1'b0);
        drain();

        pulse_recal();
        calibrate(1, 110, 0);
        for (int i = 0; i < 3; i++) run_window(2, 0, 0, 1'b0);
        drain();

        pulse_recal();
        calibrate(1, 140, 10);
        calibrate(0, 128, 0);
        run_window(0, 255, 0, 1'b0);
        run_window(0, 200, 0, 1'b1);
        calibrate(1, 100, 0);
        chk("recal_volt_hold_after_cal", volt, m_volt);
        chk("recal_sign_hold_after_cal", sign, m_sign);
        run_window(2, 0, 0, 1'b0);
        run_window(0, 0, 0, 1'b0);
        drain();

        for (int i = 0; i < 5; i++) samp(200, 1'b0);
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        chk_reset_state("midrun_reset");
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        m_volt = 0;
        m_sign = 0;
        calibrate(0, 128, 0);
        run_window(0, 0, 0, 1'b0);
        run_window(2, 0, 0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
